cache_req_arb: RTL and testbench
================================

# cache_req_arb

Two-master request arbiter and response router sitting directly upstream of the cache controller's p0 port. It merges a fetch master (m0) and a load/store master (m1) onto the single p0 request handshake using a locked round-robin grant. It records the owner of every issued read in an in-order ID FIFO, then steers each returned read datum back to the master that issued it. Writes produce no response and do not occupy the FIFO.

## Interface
- OUTSTANDING, 4 — maximum reads in flight; power of two, at least 2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mN_uvld_i  in  1  request valid from master N (N = 0, 1)
- mN_urdy_o  out  1  request accepted from master N
- mN_addr_i  in  32  byte address
- mN_web_i  in  1  0 = write, 1 = read
- mN_wdat_i  in  32  write data
- mN_wmask_i  in  4  byte write mask
- mN_dvld_o  out  1  read response valid to master N
- mN_drdy_i  in  1  master N ready for response
- mN_ddat_o  out  32  read response data
- p0_uvld_o  out  1  request valid to cache
- p0_urdy_i  in  1  cache request ready
- p0_addr_o, p0_web_o, p0_wdat_o, p0_wmask_o  out  32/1/32/4  muxed request fields
- p0_dvld_i  in  1  cache read response valid
- p0_drdy_o  out  1  ready to cache
- p0_ddat_i  in  32  cache read data
- err_o  out  1  sticky protocol error

## Operation
- Grant selection:
  - If lock_q is set, the grant is held on gnt_q.
  - Otherwise, a single requester wins.
  - If both masters request, the master not equal to rr_q wins; rr_q holds the last master served.
- Blocking: a read request is ineligible while the FIFO is full. A write request is never blocked by the FIFO. A blocked master does not take the grant, so the other master may still win.
- p0 fields are driven from the granted master; p0_uvld_o is the granted master's uvld qualified by eligibility.
- mN_urdy_o = granted(N) & p0_urdy_i & eligible(N).
- Transfer: occurs when p0_uvld_o & p0_urdy_i. On transfer:
  - rr_q ← granted index.
  - lock_q ← 0.
  - If the request is a read, push the granted index into the FIFO.
- Stall: if p0_uvld_o & !p0_urdy_i, then lock_q ← 1 and gnt_q ← granted index. Request fields to the cache must stay stable until accepted; masters hold their request fields stable while uvld is high.
- Response routing:
  - head = FIFO head ID.
  - mN_dvld_o = p0_dvld_i & !empty & (head == N).
  - mN_ddat_o = p0_ddat_i for both masters.
  - p0_drdy_o = empty ? 1 : m[head]_drdy_i.
  - Pop when p0_dvld_i & p0_drdy_o & !empty.
- Errors:
  - p0_dvld_i while the FIFO is empty: the response is dropped and err_o ← 1 until reset.
  - A push while full cannot occur by construction.
- Simultaneous push and pop:
  - Both take effect in the same cycle and the count is unchanged.
  - Pushing while full is disallowed even when a pop happens in that cycle; full gates eligibility combinationally from registered count only.
- Counters: pointers are log2(OUTSTANDING) bits and wrap naturally. The count is log2(OUTSTANDING)+1 bits.
- Reset mid-operation:
  - The FIFO empties and lock/rr/err clear.
  - Responses for reads that were in flight and arrive after reset are treated as the empty-FIFO error case.

## Timing
- Request path is combinational master→p0, with zero added latency. Grant is decided in the same cycle.
- Response path is combinational p0→master, with zero added latency.
- Reset values:
  - Registers: rr_q = 1 (m0 has first priority), lock_q = 0, gnt_q = 0, FIFO empty, err_o = 0.
  - Outputs with no master valid: p0_uvld_o = 0, all mN_urdy_o = 0, all mN_dvld_o = 0, p0_drdy_o = 1.
- Throughput: one request per cycle. Alternating masters under continuous contention: m0, m1, m0, …
- An ID is pushed on the transfer cycle and is visible at the FIFO head from the next cycle. The cache cannot respond in the issue cycle.

## Structure
- Package cache_pkg holds:
  - cache_req_t: addr, web, wdat, wmask.
  - OUTSTANDING_DEFAULT.
- Masters are packed into cache_req_t arrays internally to mux by index.
- Sub-module cache_id_fifo: synchronous FIFO with parameters DEPTH and WIDTH = 1 and asynchronous reset. It exposes push, pop, head, full, empty and count.

## Test plan
- Single m0 read of 0x0000_0040 with p0_urdy_i=1 → p0_addr_o=0x40 in the same cycle. The FIFO holds 0. A later p0_dvld_i with data 0xDEADBEEF → m0_dvld_o=1, m1_dvld_o=0.
- Both masters issue reads every cycle for 8 cycles, with the cache always ready and responding in order → grants m0,m1,m0,m1…, and each response arrives at its issuing master.
- With OUTSTANDING=4 and no responses, 4 m1 reads fill the FIFO. Then:
  - A 5th m1 read → m1_urdy_o=0.
  - A simultaneous m0 write to 0x80 → accepted.
  - One response → the 5th read is accepted on the next cycle.
- m0 read stalled 3 cycles by p0_urdy_i=0 while m1 raises uvld → grant stays on m0 with p0_addr_o stable. m1 is granted in the cycle after the m0 transfer.
- Response arrives with m1_drdy_i=0 and head=1 → p0_drdy_o=0 and the FIFO is not popped. When m1_drdy_i rises, the pop occurs.
- p0_dvld_i with an empty FIFO → err_o=1 and stays set. Asserting reset mid-traffic → err_o=0, FIFO empty, p0_drdy_o=1 within the reset cycle.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache request arbiter: muxed request record and default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

  localparam int OUTSTANDING_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        web;    // 0 = write, 1 = read
    logic [31:0] wdat;
    logic [3:0]  wmask;
  } cache_req_t;

endpackage

// File: rtl/cache_id_fifo.sv
// In-order FIFO of read-owner IDs between request issue and response return.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none internally; caller must not push when full or pop when empty.
module cache_id_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEFAULT,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_id,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  // Pointers wrap naturally; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset: only entries between the pointers are ever consumed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/cache_req_arb.sv
// Merges fetch (m0) and load/store (m1) masters onto cache p0 and routes read data back.
// Latency: zero-cycle combinational request and response paths; grant decided same cycle.
// Backpressure: p0_urdy_i low locks the grant; reads blocked while the owner FIFO is full.
module cache_req_arb
  import cache_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_uvld_i,
  output logic        m0_urdy_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_web_i,
  input  logic [31:0] m0_wdat_i,
  input  logic [3:0]  m0_wmask_i,
  output logic        m0_dvld_o,
  input  logic        m0_drdy_i,
  output logic [31:0] m0_ddat_o,
  input  logic        m1_uvld_i,
  output logic        m1_urdy_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_web_i,
  input  logic [31:0] m1_wdat_i,
  input  logic [3:0]  m1_wmask_i,
  output logic        m1_dvld_o,
  input  logic        m1_drdy_i,
  output logic [31:0] m1_ddat_o,
  output logic        p0_uvld_o,
  input  logic        p0_urdy_i,
  output logic [31:0] p0_addr_o,
  output logic        p0_web_o,
  output logic [31:0] p0_wdat_o,
  output logic [3:0]  p0_wmask_o,
  input  logic        p0_dvld_i,
  output logic        p0_drdy_o,
  input  logic [31:0] p0_ddat_i,
  output logic        err_o
);

  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

  cache_req_t    req [2];
  cache_req_t    sel;
  logic [1:0]    uvld;
  logic [1:0]    elig;
  logic [1:0]    drdy;
  logic          gnt;
  logic          gnt_q;
  logic          rr_q;
  logic          lock_q;
  logic          err_q;
  logic          xfer;
  logic          stall;
  logic          fifo_push;
  logic          fifo_pop;
  logic          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] id_cnt;

  // Pack master request fields so the p0 mux is a single index.
  always_comb begin
    req[0] = cache_req_t'{addr: m0_addr_i, web: m0_web_i, wdat: m0_wdat_i, wmask: m0_wmask_i};
    req[1] = cache_req_t'{addr: m1_addr_i, web: m1_web_i, wdat: m1_wdat_i, wmask: m1_wmask_i};
  end

  assign uvld = {m1_uvld_i, m0_uvld_i};
  assign drdy = {m1_drdy_i, m0_drdy_i};

  // Reads need a free owner slot (registered count only); writes are always eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = uvld[i] & (~req[i].web | ~fifo_full);
    end
  end

  // Hold the stalled grant; otherwise round-robin among eligible masters, m0 by default.
  always_comb begin
    gnt = 1'b0;
    if (lock_q)                   gnt = gnt_q;
    else if (elig[0] && elig[1])  gnt = ~rr_q;
    else if (elig[1])             gnt = 1'b1;
  end

  assign sel        = req[gnt];
  assign p0_uvld_o  = elig[gnt];
  assign p0_addr_o  = sel.addr;
  assign p0_web_o   = sel.web;
  assign p0_wdat_o  = sel.wdat;
  assign p0_wmask_o = sel.wmask;

  assign m0_urdy_o  = ~gnt & p0_urdy_i & elig[0];
  assign m1_urdy_o  =  gnt & p0_urdy_i & elig[1];

  assign xfer       = p0_uvld_o & p0_urdy_i;
  assign stall      = p0_uvld_o & ~p0_urdy_i;
  assign fifo_push  = xfer & sel.web;

  // Round-robin pointer, stall lock and sticky orphan-response error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q   <= 1'b1;
      lock_q <= 1'b0;
      gnt_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (xfer) begin
        rr_q   <= gnt;
        lock_q <= 1'b0;
      end else if (stall) begin
        lock_q <= 1'b1;
        gnt_q  <= gnt;
      end
      if (p0_dvld_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  // Responses go to the owner at the FIFO head; orphans are absorbed.
  assign p0_drdy_o = fifo_empty | drdy[head];
  assign fifo_pop  = p0_dvld_i & p0_drdy_o & ~fifo_empty;
  assign m0_dvld_o = p0_dvld_i & ~fifo_empty & ~head;
  assign m1_dvld_o = p0_dvld_i & ~fifo_empty &  head;
  assign m0_ddat_o = p0_ddat_i;
  assign m1_ddat_o = p0_ddat_i;

  cache_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (gnt),
    .pop     (fifo_pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (id_cnt)
  );

  // Eligibility gating guarantees the owner FIFO never overflows.
  assert property (@(posedge clk) disable iff (reset) !(fifo_push && (id_cnt == FULL_CNT)));

endmodule

// File: tb/tb_cache_req_arb.sv
module tb_cache_req_arb;

  localparam int OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_uvld_i, m0_urdy_o, m0_web_i, m0_dvld_o, m0_drdy_i;
  logic [31:0] m0_addr_i, m0_wdat_i, m0_ddat_o;
  logic [3:0]  m0_wmask_i;
  logic        m1_uvld_i, m1_urdy_o, m1_web_i, m1_dvld_o, m1_drdy_i;
  logic [31:0] m1_addr_i, m1_wdat_i, m1_ddat_o;
  logic [3:0]  m1_wmask_i;
  logic        p0_uvld_o, p0_urdy_i, p0_web_o, p0_dvld_i, p0_drdy_o, err_o;
  logic [31:0] p0_addr_o, p0_wdat_o, p0_ddat_i;
  logic [3:0]  p0_wmask_o;

  always #5 clk = ~clk;

  cache_req_arb #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset),
    .m0_uvld_i(m0_uvld_i), .m0_urdy_o(m0_urdy_o), .m0_addr_i(m0_addr_i), .m0_web_i(m0_web_i),
    .m0_wdat_i(m0_wdat_i), .m0_wmask_i(m0_wmask_i), .m0_dvld_o(m0_dvld_o), .m0_drdy_i(m0_drdy_i),
    .m0_ddat_o(m0_ddat_o),
    .m1_uvld_i(m1_uvld_i), .m1_urdy_o(m1_urdy_o), .m1_addr_i(m1_addr_i), .m1_web_i(m1_web_i),
    .m1_wdat_i(m1_wdat_i), .m1_wmask_i(m1_wmask_i), .m1_dvld_o(m1_dvld_o), .m1_drdy_i(m1_drdy_i),
    .m1_ddat_o(m1_ddat_o),
    .p0_uvld_o(p0_uvld_o), .p0_urdy_i(p0_urdy_i), .p0_addr_o(p0_addr_o), .p0_web_o(p0_web_o),
    .p0_wdat_o(p0_wdat_o), .p0_wmask_o(p0_wmask_o), .p0_dvld_i(p0_dvld_i), .p0_drdy_o(p0_drdy_o),
    .p0_ddat_i(p0_ddat_i), .err_o(err_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data the bench's cache returns for an address.
  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic v, input logic [31:0] a, input logic web,
                       input logic [31:0] wd = 32'h0, input logic [3:0] wm = 4'h0);
    if (n == 0) begin
      m0_uvld_i = v; m0_addr_i = a; m0_web_i = web; m0_wdat_i = wd; m0_wmask_i = wm;
    end else begin
      m1_uvld_i = v; m1_addr_i = a; m1_web_i = web; m1_wdat_i = wd; m1_wmask_i = wm;
    end
  endtask

  // ---------------- reference model for the randomized phase ----------------
  bit          rand_on = 1'b0;
  int          last_m;            // master served last
  int          lock_m;            // master whose stalled request is held, -1 if none
  int          owners[$];         // owner of each outstanding read, oldest first
  logic [31:0] exp0[$], exp1[$];  // read data each master must still receive, in order
  logic [31:0] cpend[$];          // bench cache: data of accepted reads not yet returned
  int          md_occ, md_head;
  logic        md_e0, md_e1, md_w, md_ev, md_edr, md_web;

  // Request/response model: winner from round-robin rules, FIFO as a queue of owners.
  always @(negedge clk) begin
    if (rand_on) begin
      md_occ  = owners.size();
      md_head = (md_occ > 0) ? owners[0] : 0;
      md_edr  = (md_occ == 0) ? 1'b1 : ((md_head == 1) ? m1_drdy_i : m0_drdy_i);
      check1("rnd_p0_drdy", p0_drdy_o, md_edr);
      check1("rnd_m0_dvld", m0_dvld_o, p0_dvld_i && md_occ > 0 && md_head == 0);
      check1("rnd_m1_dvld", m1_dvld_o, p0_dvld_i && md_occ > 0 && md_head == 1);
      if (p0_dvld_i && md_occ > 0 && md_edr) void'(owners.pop_front());

      md_e0 = m0_uvld_i && (!m0_web_i || md_occ < OUT);
      md_e1 = m1_uvld_i && (!m1_web_i || md_occ < OUT);
      if (lock_m >= 0)         md_w = (lock_m == 1);
      else if (md_e0 && md_e1) md_w = (last_m == 0);
      else                     md_w = md_e1;
      md_ev = md_w ? md_e1 : md_e0;
      check1("rnd_p0_uvld", p0_uvld_o, md_ev);
      check1("rnd_m0_urdy", m0_urdy_o, md_ev && !md_w && p0_urdy_i);
      check1("rnd_m1_urdy", m1_urdy_o, md_ev && md_w && p0_urdy_i);
      if (md_ev) begin
        md_web = md_w ? m1_web_i : m0_web_i;
        check32("rnd_p0_addr", p0_addr_o, md_w ? m1_addr_i : m0_addr_i);
        check1("rnd_p0_web", p0_web_o, md_web);
        check32("rnd_p0_wdat", p0_wdat_o, md_w ? m1_wdat_i : m0_wdat_i);
        check32("rnd_p0_wmask", {28'h0, p0_wmask_o}, {28'h0, md_w ? m1_wmask_i : m0_wmask_i});
        if (p0_urdy_i) begin
          last_m = md_w ? 1 : 0;
          lock_m = -1;
          if (md_web) begin
            owners.push_back(md_w ? 1 : 0);
            if (md_w) exp1.push_back(rdata(m1_addr_i));
            else      exp0.push_back(rdata(m0_addr_i));
          end
        end else begin
          lock_m = md_w ? 1 : 0;
        end
      end
    end
  end

  // Response monitor: each delivered datum must be the oldest one owed to that master.
  always @(negedge clk) begin
    if (rand_on) begin
      check1("rnd_dvld_onehot", m0_dvld_o & m1_dvld_o, 1'b0);
      check1("rnd_err", err_o, 1'b0);
      if (m0_dvld_o && m0_drdy_i) begin
        check1("rsp0_pending", exp0.size() != 0, 1'b1);
        if (exp0.size() != 0) check32("rsp0_data", m0_ddat_o, exp0.pop_front());
      end
      if (m1_dvld_o && m1_drdy_i) begin
        check1("rsp1_pending", exp1.size() != 0, 1'b1);
        if (exp1.size() != 0) check32("rsp1_data", m1_ddat_o, exp1.pop_front());
      end
    end
  end

  task automatic new_req(input int n, input bit en);
    logic v;
    v = en && ($urandom_range(0, 3) != 0);
    set_m(n, v, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0, $urandom, 4'($urandom));
  endtask

  // One randomized cycle: masters hold until accepted, cache returns reads in order.
  task automatic rand_cycle(input bit en);
    logic a0, a1, rt;
    @(negedge clk);
    a0 = m0_uvld_i & m0_urdy_o;
    a1 = m1_uvld_i & m1_urdy_o;
    rt = p0_dvld_i & p0_drdy_o;
    if (p0_uvld_o && p0_urdy_i && p0_web_o) cpend.push_back(rdata(p0_addr_o));
    step();
    if (rt && cpend.size() > 0) void'(cpend.pop_front());
    if (!m0_uvld_i || a0) new_req(0, en);
    if (!m1_uvld_i || a1) new_req(1, en);
    p0_urdy_i = ($urandom_range(0, 3) != 0);
    m0_drdy_i = ($urandom_range(0, 3) != 0);
    m1_drdy_i = ($urandom_range(0, 3) != 0);
    if (cpend.size() > 0 && (p0_dvld_i || $urandom_range(0, 2) != 0)) begin
      p0_dvld_i = 1'b1;
      p0_ddat_i = cpend[0];
    end else begin
      p0_dvld_i = 1'b0;
      p0_ddat_i = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int          k0, k1;
    int          pown[$];
    logic [31:0] pdat[$];
    logic [31:0] ea;
    logic        ew;
    bit          done;

    reset = 1'b1;
    set_m(0, 1'b0, 32'h0, 1'b1);
    set_m(1, 1'b0, 32'h0, 1'b1);
    m0_drdy_i = 1'b1; m1_drdy_i = 1'b1;
    p0_urdy_i = 1'b0; p0_dvld_i = 1'b0; p0_ddat_i = 32'h0;

    // Reset state
    @(negedge clk);
    check1("rst_p0_uvld", p0_uvld_o, 1'b0);
    check1("rst_m0_urdy", m0_urdy_o, 1'b0);
    check1("rst_m1_urdy", m1_urdy_o, 1'b0);
    check1("rst_m0_dvld", m0_dvld_o, 1'b0);
    check1("rst_m1_dvld", m1_dvld_o, 1'b0);
    check1("rst_p0_drdy", p0_drdy_o, 1'b1);
    check1("rst_err", err_o, 1'b0);
    step();
    reset = 1'b0;

    // Single m0 read and its response
    set_m(0, 1'b1, 32'h40, 1'b1);
    p0_urdy_i = 1'b1;
    @(negedge clk);
    check1("rd0_p0_uvld", p0_uvld_o, 1'b1);
    check32("rd0_p0_addr", p0_addr_o, 32'h40);
    check1("rd0_m0_urdy", m0_urdy_o, 1'b1);
    check1("rd0_m1_urdy", m1_urdy_o, 1'b0);
    step();
    m0_uvld_i = 1'b0;
    p0_dvld_i = 1'b1; p0_ddat_i = 32'hDEADBEEF;
    @(negedge clk);
    check1("rd0_m0_dvld", m0_dvld_o, 1'b1);
    check1("rd0_m1_dvld", m1_dvld_o, 1'b0);
    check32("rd0_m0_ddat", m0_ddat_o, 32'hDEADBEEF);
    step();
    p0_dvld_i = 1'b0;

    // Continuous contention: m0 was served last, so m1 wins first, then alternation
    k0 = 0; k1 = 0;
    for (int i = 0; i < 9; i++) begin
      set_m(0, i < 8, 32'h1000 + 32'(k0 * 4), 1'b1);
      set_m(1, i < 8, 32'h2000 + 32'(k1 * 4), 1'b1);
      p0_dvld_i = (pown.size() > 0);
      p0_ddat_i = (pdat.size() > 0) ? pdat[0] : 32'h0;
      @(negedge clk);
      ew = (i % 2 == 0);
      if (i < 8) begin
        ea = ew ? 32'h2000 + 32'(k1 * 4) : 32'h1000 + 32'(k0 * 4);
        check1("alt_m0_urdy", m0_urdy_o, !ew);
        check1("alt_m1_urdy", m1_urdy_o, ew);
        check32("alt_p0_addr", p0_addr_o, ea);
      end
      if (pown.size() > 0) begin
        check1("alt_m0_dvld", m0_dvld_o, pown[0] == 0);
        check1("alt_m1_dvld", m1_dvld_o, pown[0] == 1);
        check32("alt_ddat", (pown[0] == 0) ? m0_ddat_o : m1_ddat_o, pdat[0]);
        void'(pown.pop_front());
        void'(pdat.pop_front());
      end
      if (i < 8) begin
        pown.push_back(ew ? 1 : 0);
        pdat.push_back(rdata(ea));
        if (ew) k1++; else k0++;
      end
      step();
    end
    p0_dvld_i = 1'b0;

    // Fill the owner FIFO with m1 reads
    for (int i = 0; i < OUT; i++) begin
      set_m(1, 1'b1, 32'h3000 + 32'(i * 4), 1'b1);
      @(negedge clk);
      check1("fill_m1_urdy", m1_urdy_o, 1'b1);
      step();
    end
    // Fifth read blocked, concurrent write still goes through
    set_m(1, 1'b1, 32'h3010, 1'b1);
    set_m(0, 1'b1, 32'h80, 1'b0, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check1("full_m1_urdy", m1_urdy_o, 1'b0);
    check1("full_m0_wr_urdy", m0_urdy_o, 1'b1);
    check32("full_wr_addr", p0_addr_o, 32'h80);
    check1("full_wr_web", p0_web_o, 1'b0);
    check32("full_wr_wdat", p0_wdat_o, 32'hCAFEF00D);
    step();
    m0_uvld_i = 1'b0;
    @(negedge clk);
    check1("full_p0_uvld", p0_uvld_o, 1'b0);
    step();
    p0_dvld_i = 1'b1; p0_ddat_i = 32'hA5A50001;
    @(negedge clk);
    check1("full_rsp_m1_dvld", m1_dvld_o, 1'b1);
    check1("full_rsp_m0_dvld", m0_dvld_o, 1'b0);
    check1("full_pop_cycle_urdy", m1_urdy_o, 1'b0);
    step();
    p0_dvld_i = 1'b0;
    @(negedge clk);
    check1("after_pop_m1_urdy", m1_urdy_o, 1'b1);
    check32("after_pop_addr", p0_addr_o, 32'h3010);
    step();
    m1_uvld_i = 1'b0;
    for (int i = 0; i < OUT; i++) begin
      p0_dvld_i = 1'b1; p0_ddat_i = 32'(i);
      @(negedge clk);
      check1("drain_m1_dvld", m1_dvld_o, 1'b1);
      step();
    end
    p0_dvld_i = 1'b0; m0_drdy_i = 1'b0; m1_drdy_i = 1'b0;
    @(negedge clk);
    check1("drain_empty_drdy", p0_drdy_o, 1'b1);
    step();
    m0_drdy_i = 1'b1; m1_drdy_i = 1'b1;

    // Stall: make m0 served last so only the lock keeps m0 granted
    set_m(0, 1'b1, 32'h90, 1'b0);
    step();
    set_m(0, 1'b1, 32'h100, 1'b1);
    p0_urdy_i = 1'b0;
    @(negedge clk);
    check1("stall_p0_uvld", p0_uvld_o, 1'b1);
    check32("stall_addr0", p0_addr_o, 32'h100);
    check1("stall_m0_urdy", m0_urdy_o, 1'b0);
    step();
    set_m(1, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check32("stall_addr_held", p0_addr_o, 32'h100);
      check1("stall_m1_urdy", m1_urdy_o, 1'b0);
      step();
    end
    p0_urdy_i = 1'b1;
    @(negedge clk);
    check1("unstall_m0_urdy", m0_urdy_o, 1'b1);
    check1("unstall_m1_urdy", m1_urdy_o, 1'b0);
    check32("unstall_addr", p0_addr_o, 32'h100);
    step();
    m0_uvld_i = 1'b0;
    @(negedge clk);
    check1("next_m1_urdy", m1_urdy_o, 1'b1);
    check32("next_m1_addr", p0_addr_o, 32'h200);
    step();
    m1_uvld_i = 1'b0;

    // Response backpressure from m1
    p0_dvld_i = 1'b1; p0_ddat_i = 32'h11111111; m1_drdy_i = 1'b0;
    @(negedge clk);
    check1("bp_m0_dvld", m0_dvld_o, 1'b1);
    step();
    p0_ddat_i = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check1("bp_p0_drdy_low", p0_drdy_o, 1'b0);
      check1("bp_m1_dvld_held", m1_dvld_o, 1'b1);
      step();
    end
    m1_drdy_i = 1'b1;
    @(negedge clk);
    check1("bp_p0_drdy_high", p0_drdy_o, 1'b1);
    check32("bp_m1_ddat", m1_ddat_o, 32'h22222222);
    step();
    p0_dvld_i = 1'b0;
    @(negedge clk);
    check1("bp_no_err", err_o, 1'b0);
    step();

    // Orphan response sets a sticky error
    p0_dvld_i = 1'b1; p0_ddat_i = 32'h33333333;
    @(negedge clk);
    check1("orph_m0_dvld", m0_dvld_o, 1'b0);
    check1("orph_m1_dvld", m1_dvld_o, 1'b0);
    check1("orph_p0_drdy", p0_drdy_o, 1'b1);
    step();
    p0_dvld_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("orph_err_sticky", err_o, 1'b1);
      step();
    end

    // Reset with a read in flight; its late response counts as an orphan
    set_m(0, 1'b1, 32'h400, 1'b1);
    step();
    m0_uvld_i = 1'b0;
    p0_dvld_i = 1'b1; p0_ddat_i = 32'h77; m0_drdy_i = 1'b0;
    @(negedge clk);
    check1("mid_pre_drdy", p0_drdy_o, 1'b0);
    #2 reset = 1'b1;
    #1;
    check1("mid_rst_err", err_o, 1'b0);
    check1("mid_rst_drdy", p0_drdy_o, 1'b1);
    check1("mid_rst_m0_dvld", m0_dvld_o, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check1("late_m0_dvld", m0_dvld_o, 1'b0);
    step();
    p0_dvld_i = 1'b0; m0_drdy_i = 1'b1;
    @(negedge clk);
    check1("late_err", err_o, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Randomized traffic against the model
    last_m = 1; lock_m = -1;
    rand_on = 1'b1;
    for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      rand_cycle(1'b0);
      done = !m0_uvld_i && !m1_uvld_i && !p0_dvld_i && cpend.size() == 0 &&
             exp0.size() == 0 && exp1.size() == 0;
    end
    rand_on = 1'b0;
    check1("drain_complete", done, 1'b1);
    check1("model_fifo_empty", owners.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
